// File: rtl/layer_mem_pkg.sv
// Shared types and defaults for layer memory writers.
package layer_mem_pkg;

    // Writer sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } lmw_state_t;

    // Default geometry: words per channel, channel count, start-to-write latency.
    localparam int unsigned DEF_DEPTH    = 16;
    localparam int unsigned DEF_CHANNELS = 4;
    localparam int unsigned DEF_LATENCY  = 1;

    // Bits needed to index n items, never less than one.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_wrap_counter.sv
// Modulo-LIMIT up counter with carry out, used for word address and channel index.
module mem_wrap_counter #(
    parameter int unsigned LIMIT = 16,
    parameter int unsigned W     = 4
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    input  logic         hold,
    output logic [W-1:0] count,
    output logic         carry
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    // Carry marks an increment request at the last value, independent of hold.
    always_comb begin
        carry = inc && (count == LAST);
    end

    // Count register: clear restarts, hold suppresses the update but not the carry.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && !hold) begin
            count <= carry ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/layer_mem_writer.sv
// Sequences DEPTH*CHANNELS write strobes across banks after a start-to-data latency.
module layer_mem_writer
    import layer_mem_pkg::*;
#(
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned LATENCY  = DEF_LATENCY,
    localparam int unsigned ADDR_W  = width_of(DEPTH),
    localparam int unsigned CH_W    = width_of(CHANNELS)
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                enable,
    input  logic                in_valid,
    output logic [ADDR_W-1:0]   addr,
    output logic [CH_W-1:0]     chan,
    output logic [CHANNELS-1:0] we,
    output logic                busy,
    output logic                done
);

    localparam int unsigned LAT_W = width_of(LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    lmw_state_t       state;
    lmw_state_t       state_next;
    logic             accept;
    logic             write_fire;
    logic             lat_inc;
    logic [LAT_W-1:0] lat_cnt;
    logic             addr_carry;
    logic             last_write;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus combinational strobes (we, busy).
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        write_fire = 1'b0;
        lat_inc    = 1'b0;
        we         = '0;
        busy       = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (LATENCY > 0) ? ST_WAIT : ST_WRITE;
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (enable) begin
                    lat_inc = 1'b1;
                    if (lat_cnt == LAT_LAST) begin
                        state_next = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                busy = 1'b1;
                if (enable && in_valid) begin
                    write_fire = 1'b1;
                    we         = CHANNELS'(1) << chan;
                    if (last_write) begin
                        state_next = ST_DONE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Latency counter: restarts on an accepted start, advances on enabled WAIT cycles.
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            lat_cnt <= '0;
        end else if (lat_inc) begin
            lat_cnt <= lat_cnt + 1'b1;
        end
    end

    // Done flag mirrors entry into DONE, registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= (state_next == ST_DONE);
        end
    end

    // The channel counter's carry marks the final word of the pass; it freezes
    // both counters so addr/chan stay at their last values in DONE.
    mem_wrap_counter #(
        .LIMIT (DEPTH),
        .W     (ADDR_W)
    ) u_addr_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .inc   (write_fire),
        .hold  (last_write),
        .count (addr),
        .carry (addr_carry)
    );

    mem_wrap_counter #(
        .LIMIT (CHANNELS),
        .W     (CH_W)
    ) u_chan_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .inc   (addr_carry),
        .hold  (last_write),
        .count (chan),
        .carry (last_write)
    );

endmodule

// File: tb/tb_layer_mem_writer.sv
// Scoreboard bench for layer_mem_writer: default geometry plus a 10x3, zero-latency instance.
module tb_layer_mem_writer;

    localparam int AD = 16;
    localparam int AC = 4;
    localparam int BD = 10;
    localparam int BC = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset = 1'b1, a_start = 1'b0, a_en = 1'b0, a_iv = 1'b0;
    logic [3:0] a_addr;
    logic [1:0] a_chan;
    logic [3:0] a_we;
    logic       a_busy, a_done;

    logic       b_reset = 1'b1, b_start = 1'b0, b_en = 1'b0, b_iv = 1'b0;
    logic [3:0] b_addr;
    logic [1:0] b_chan;
    logic [2:0] b_we;
    logic       b_busy, b_done;

    layer_mem_writer #(.DEPTH(AD), .CHANNELS(AC), .LATENCY(1)) dut_a (
        .clk(clk), .reset(a_reset), .start(a_start), .enable(a_en), .in_valid(a_iv),
        .addr(a_addr), .chan(a_chan), .we(a_we), .busy(a_busy), .done(a_done)
    );

    layer_mem_writer #(.DEPTH(BD), .CHANNELS(BC), .LATENCY(0)) dut_b (
        .clk(clk), .reset(b_reset), .start(b_start), .enable(b_en), .in_valid(b_iv),
        .addr(b_addr), .chan(b_chan), .we(b_we), .busy(b_busy), .done(b_done)
    );

    int total = 0;
    int bad   = 0;
    int sb_a[$];
    int sb_b[$];
    int ev_a = 0;
    int ev_b = 0;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A pass is linear word index 0..N-1, channel-major; a start is only
    // taken when no pass is outstanding in the model.
    task automatic start_a();
        a_start = 1'b1;
        if (sb_a.size() == 0)
            for (int i = 0; i < AD * AC; i++) sb_a.push_back(i);
        step();
        a_start = 1'b0;
    endtask

    task automatic start_b();
        b_start = 1'b1;
        if (sb_b.size() == 0)
            for (int i = 0; i < BD * BC; i++) sb_b.push_back(i);
        step();
        b_start = 1'b0;
    endtask

    // Monitor A: every write strobe must match the next expected word.
    always @(negedge clk) begin : mon_a
        int e;
        if (!a_reset && a_we != 0) begin
            if (sb_a.size() == 0) begin
                chk("a_unexpected_we", int'(a_we), 0);
            end else begin
                e = sb_a.pop_front();
                chk("a_we", int'(a_we), 1 << (e / AD));
                chk("a_addr", int'(a_addr), e % AD);
                chk("a_chan", int'(a_chan), e / AD);
                ev_a++;
            end
        end
    end

    // Monitor B: same rule for the 10x3 instance.
    always @(negedge clk) begin : mon_b
        int e;
        if (!b_reset && b_we != 0) begin
            if (sb_b.size() == 0) begin
                chk("b_unexpected_we", int'(b_we), 0);
            end else begin
                e = sb_b.pop_front();
                chk("b_we", int'(b_we), 1 << (e / BD));
                chk("b_addr", int'(b_addr), e % BD);
                chk("b_chan", int'(b_chan), e / BD);
                ev_b++;
            end
        end
    end

    initial begin
        int n;
        int found;

        // Reset with active-looking inputs.
        a_en = 1'b1; a_iv = 1'b1; a_start = 1'b1;
        b_en = 1'b1; b_iv = 1'b1; b_start = 1'b1;
        step(); step();
        chk("rst_addr", int'(a_addr), 0);
        chk("rst_chan", int'(a_chan), 0);
        chk("rst_done", int'(a_done), 0);
        chk("rst_busy", int'(a_busy), 0);
        chk("rst_we", int'(a_we), 0);
        chk("b_rst_busy", int'(b_busy), 0);
        a_start = 1'b0; b_start = 1'b0;
        a_reset = 1'b0; b_reset = 1'b0;
        step();
        chk("idle_busy", int'(a_busy), 0);

        // Pass 1: continuous data, one WAIT cycle then 64 writes.
        ev_a = 0;
        start_a();
        chk("p1_wait_busy", int'(a_busy), 1);
        chk("p1_wait_we", int'(a_we), 0);
        n = 0;
        while (!a_done && n < 300) begin step(); n++; end
        chk("p1_cycles", n, 65);
        chk("p1_events", ev_a, 64);
        chk("p1_sb_empty", sb_a.size(), 0);
        chk("p1_final_addr", int'(a_addr), AD - 1);
        chk("p1_final_chan", int'(a_chan), AC - 1);
        chk("p1_done_busy", int'(a_busy), 0);
        step(); step();
        chk("p1_done_held", int'(a_done), 1);
        chk("p1_done_we", int'(a_we), 0);

        // Pass 2: restart from DONE, in_valid toggling, stray start mid-WRITE.
        ev_a = 0;
        a_iv = 1'b1;
        start_a();
        chk("p2_done_fall", int'(a_done), 0);
        n = 0;
        while (!a_done && n < 400) begin
            a_iv = ~a_iv;
            a_start = (n == 40);
            step();
            n++;
        end
        a_start = 1'b0;
        chk("p2_cycles", n, 128);
        chk("p2_events", ev_a, 64);
        chk("p2_sb_empty", sb_a.size(), 0);

        // Pass 3: enable low for 5 cycles in WAIT and at addr=7, chan=2.
        ev_a = 0;
        a_iv = 1'b1;
        start_a();
        a_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("p3_wfrz_busy", int'(a_busy), 1);
            chk("p3_wfrz_we", int'(a_we), 0);
            chk("p3_wfrz_addr", int'(a_addr), 0);
        end
        a_en = 1'b1;
        chk("p3_still_wait", int'(a_we), 0);
        step();
        chk("p3_first_we", int'(a_we), 1);
        found = 0; n = 0;
        while (n < 200) begin
            if (a_addr == 4'd7 && a_chan == 2'd2) begin found = 1; break; end
            step(); n++;
        end
        chk("p3_reach_7_2", found, 1);
        a_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("p3_frz_addr", int'(a_addr), 7);
            chk("p3_frz_chan", int'(a_chan), 2);
            chk("p3_frz_we", int'(a_we), 0);
        end
        a_en = 1'b1;
        n = 0;
        while (!a_done && n < 300) begin step(); n++; end
        chk("p3_events", ev_a, 64);
        chk("p3_sb_empty", sb_a.size(), 0);

        // Pass 4: reset with start high at addr=9, chan=1.
        start_a();
        found = 0; n = 0;
        while (n < 200) begin
            if (a_addr == 4'd9 && a_chan == 2'd1) begin found = 1; break; end
            step(); n++;
        end
        chk("p4_reach_9_1", found, 1);
        a_reset = 1'b1; a_start = 1'b1;
        step();
        a_reset = 1'b0; a_start = 1'b0;
        sb_a.delete();
        chk("p4_addr", int'(a_addr), 0);
        chk("p4_chan", int'(a_chan), 0);
        chk("p4_done", int'(a_done), 0);
        chk("p4_busy", int'(a_busy), 0);
        chk("p4_we", int'(a_we), 0);
        step(); step();
        chk("p4_no_pass", int'(a_busy), 0);

        // Pass 5: random enable and in_valid.
        ev_a = 0;
        start_a();
        n = 0;
        while (!a_done && n < 3000) begin
            a_en = ($urandom_range(0, 3) != 0);
            a_iv = $urandom_range(0, 1);
            step(); n++;
        end
        chk("p5_events", ev_a, 64);
        chk("p5_sb_empty", sb_a.size(), 0);
        chk("p5_done", int'(a_done), 1);

        // Instance B: zero latency, 10-word channels, 3 banks.
        ev_b = 0;
        start_b();
        chk("b_busy", int'(b_busy), 1);
        chk("b_first_we", int'(b_we), 1);
        n = 0;
        while (!b_done && n < 300) begin step(); n++; end
        chk("b_cycles", n, 30);
        chk("b_events", ev_b, 30);
        chk("b_final_addr", int'(b_addr), BD - 1);
        chk("b_final_chan", int'(b_chan), BC - 1);

        ev_b = 0;
        start_b();
        n = 0;
        while (!b_done && n < 2000) begin
            b_en = $urandom_range(0, 1);
            b_iv = ($urandom_range(0, 2) != 0);
            step(); n++;
        end
        chk("b_rand_events", ev_b, 30);
        chk("b_rand_sb_empty", sb_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
